operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/cpu_pkg.sv | 7 +
 rtl/bypass_mux.sv | 21 ++
 rtl/operand_fetch_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: default widths and the hard-wired zero register.
package cpu_pkg;
  localparam int          DEF_DATA_W = 32;
  localparam int          DEF_ADDR_W = 5;
  localparam int          ZERO_REG   = 0;
  localparam logic [15:0] STALL_MAX  = 16'hFFFF;
endpackage

// File: rtl/bypass_mux.sv
// Write-back forwarding for one source operand; register 0 is never forwarded.
module bypass_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] bus,
  input  logic              wb_RegWr,
  input  logic [ADDR_W-1:0] wb_RW,
  input  logic [DATA_W-1:0] wb_BusW,
  output logic [DATA_W-1:0] out
);
  logic fwd;

  always_comb begin
    fwd = wb_RegWr && (wb_RW == addr) && (addr != ADDR_W'(ZERO_REG));
    out = fwd ? wb_BusW : bus;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch pipeline register with write-back bypass, load-use interlock and flush.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  input  logic              wb_RegWr,
  input  logic [ADDR_W-1:0] wb_RW,
  input  logic [DATA_W-1:0] wb_BusW,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_is_load,
  output logic [15:0]       stall_count
);
  logic [1:0][ADDR_W-1:0] srcAddr;
  logic [1:0][DATA_W-1:0] srcBus;
  logic [1:0][DATA_W-1:0] fwdOp;
  logic                   hazard;
  logic                   accept;

  assign srcAddr = {RB, RA};
  assign srcBus  = {BusB, BusA};

  for (genvar i = 0; i < 2; i++) begin : g_byp
    bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp (
      .addr     (srcAddr[i]),
      .bus      (srcBus[i]),
      .wb_RegWr (wb_RegWr),
      .wb_RW    (wb_RW),
      .wb_BusW  (wb_BusW),
      .out      (fwdOp[i])
    );
  end

  // A load still in this register cannot feed a dependent instruction; hold it back one cycle.
  always_comb begin
    hazard   = in_valid && out_valid && out_is_load &&
               (out_dst != ADDR_W'(ZERO_REG)) &&
               ((out_dst == RA) || (out_dst == RB));
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid   <= 1'b0;
      OpA         <= '0;
      OpB         <= '0;
      out_dst     <= '0;
      out_is_load <= 1'b0;
      stall_count <= '0;
    end else begin
      if (hazard && (stall_count != STALL_MAX))
        stall_count <= stall_count + 16'd1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        OpA         <= fwdOp[0];
        OpB         <= fwdOp[1];
        out_dst     <= in_dst;
        out_is_load <= in_is_load;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
